lsu_mem_bridge: RTL and testbench

- Sits between the RV32I load/store unit and the external memory interface block.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Aligns addresses to words and issues word accesses downstream.
- Performs read-modify-write for byte and halfword stores, because the downstream path has no byte enables.
- Sign- or zero-extends load data and returns a one-cycle response strobe.

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_mem_bridge_lane.sv | 41 ++++
 rtl/lsu_mem_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_lsu_mem_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU-to-memory bridge: access-size encodings,
// FSM state encoding and the alignment check used at request accept.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

  // True when the request cannot be serviced: size 11, or an offset
  // that is not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_mem_bridge_lane.sv
// Byte-lane steering for the bridge (combinational).
// Builds the merged write word for sub-word stores and the extracted,
// sign/zero-extended value for loads. Lanes are little-endian.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [31:0] merged,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select for both directions, keyed by size and byte offset.
  always_comb begin
    merged  = rd_word;
    ld_data = rd_word;
    byte_v  = rd_word[{offset, 3'b000} +: 8];
    half_v  = rd_word[{offset[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        merged[{offset, 3'b000} +: 8] = st_data[7:0];
        ld_data = {{24{byte_v[7] & ~is_unsigned}}, byte_v};
      end
      SZ_HALF: begin
        merged[{offset[1], 4'b0000} +: 16] = st_data[15:0];
        ld_data = {{16{half_v[15] & ~is_unsigned}}, half_v};
      end
      default: begin
        merged  = st_data;
        ld_data = rd_word;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// LSU-to-memory bridge: one outstanding load/store, word-aligned downstream
// accesses, read-modify-write for byte/half stores, registered response.
// Optional watchdog on memory waits enabled by defining BRIDGE_TIMEOUT_EN.
//
// state      | meaning
// IDLE       | ready for a request (req_ready = 1)
// RD_REQ     | one-cycle read strobe
// RD_WAIT    | wait for read data; extra merge cycle for sub-word stores
// WR_REQ     | one-cycle write strobe with merged data
// WR_WAIT    | wait for write completion
// RESP       | load the response registers (strobe appears next cycle)
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] st_data_q, st_data_d;
  logic                  err_q, err_d;
  logic                  merge_q, merge_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [31:0]           lane_merged;
  logic [31:0]           lane_ld;
  logic                  to_hit;

  lsu_byte_lane u_lane (
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (uns_q),
    .st_data     (st_data_q),
    .rd_word     (rdata_q),
    .merged      (lane_merged),
    .ld_data     (lane_ld)
  );

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Watchdog down-counter: loaded on each strobe, terminal count at zero.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == ST_RD_REQ || state_q == ST_WR_REQ) begin
      to_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
    end else if ((state_q == ST_RD_WAIT && !merge_q) || state_q == ST_WR_WAIT) begin
      if (to_cnt_q != '0) to_cnt_d = to_cnt_q - 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end

  assign to_hit = (to_cnt_q == '0);
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign to_hit = 1'b0;
`endif

  // Next-state, request latching, merge and response preparation.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    st_data_d   = st_data_q;
    err_d       = err_q;
    merge_d     = merge_q;
    rdata_d     = rdata_q;
    wdata_d     = wdata_q;
    mem_cs      = 1'b0;
    rsp_valid_d = (state_q == ST_RESP);
    rsp_err_d   = (state_q == ST_RESP) & err_q;
    rsp_rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          size_d    = req_size;
          uns_d     = req_unsigned;
          addr_d    = req_addr;
          st_data_d = req_wdata;
          wdata_d   = req_wdata;
          merge_d   = 1'b0;
          err_d     = is_misaligned(req_size, req_addr[1:0]);
          if (err_d)                                 state_d = ST_RESP;
          else if (!req_we || req_size != SZ_WORD)   state_d = ST_RD_REQ;
          else                                       state_d = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        mem_cs  = 1'b1;
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // The cycle after read data arrives for a sub-word store is spent
        // registering the merged word so mem_wdata is settled at mem_cs.
        if (merge_q) begin
          wdata_d = lane_merged;
          merge_d = 1'b0;
          state_d = ST_WR_REQ;
        end else if (mem_ready) begin
          rdata_d = mem_rdata;
          if (we_q) merge_d = 1'b1;
          else      state_d = ST_RESP;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WR_REQ: begin
        mem_cs  = 1'b1;
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (mem_ready) begin
          state_d = ST_RESP;
        end else if (to_hit) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!we_q && !err_q) rsp_rdata_d = lane_ld;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      st_data_q   <= '0;
      err_q       <= 1'b0;
      merge_q     <= 1'b0;
      rdata_q     <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      st_data_q   <= st_data_d;
      err_q       <= err_d;
      merge_q     <= merge_d;
      rdata_q     <= rdata_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_we    = (state_q == ST_WR_REQ) || (state_q == ST_WR_WAIT);
  assign mem_oe    = mem_we;
  assign mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge with a fixed-latency memory responder.
module tb_lsu_mem_bridge;

  localparam int N = 2;
`ifdef BRIDGE_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_cs, mem_we, mem_oe, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  lsu_mem_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [31:0] mem [logic [31:0]];
  logic        mem_en;
  int          cs_cnt, oe_cnt, oe_bad;
  logic [31:0] last_rd_addr, last_wr_addr, last_wr_data;
  logic        last_rd_we;

  // Activity monitor.
  always @(negedge clk) begin
    if (mem_cs) cs_cnt++;
    if (mem_oe) oe_cnt++;
    if (mem_oe && !mem_we) oe_bad++;
  end

  // Memory responder: mem_ready N cycles after the mem_cs cycle.
  initial begin
    logic [31:0] a, d;
    logic        w;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_cs && mem_en && rst_n) begin
        a = mem_addr; w = mem_we; d = mem_wdata;
        if (w) begin last_wr_addr = a; last_wr_data = d; end
        else   begin last_rd_addr = a; last_rd_we = w; end
        repeat (N) @(negedge clk);
        mem_ready = 1'b1;
        if (w) mem[a] = d;
        else   mem_rdata = mem.exists(a) ? mem[a] : 32'h0;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    logic got;
    @(negedge clk);
    cs_cnt = 0; oe_cnt = 0; oe_bad = 0;
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    got = 1'b0; lat = 0; rdata = '0; err = 1'b0;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0;
        chk("req_ready_drop", {31'b0, req_ready}, 32'h0);
      end
      if (rsp_valid) begin
        got = 1'b1; lat = c; rdata = rsp_rdata; err = rsp_err;
      end
    end
    if (!got) chk("rsp_missing", 32'h0, 32'h1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, seen;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; mem_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_outputs", {26'b0, rsp_valid, rsp_err, mem_cs, mem_we, mem_oe, 1'b0}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;

    // LW
    mem[32'h100] = 32'h8899AABB;
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("lw_data", rd, 32'h8899AABB);
    chk("lw_err", {31'b0, er}, 32'h0);
    chk("lw_lat", lat, 5);
    chk("lw_cs_cnt", cs_cnt, 1);
    chk("lw_addr", last_rd_addr, 32'h100);
    chk("lw_we", {31'b0, last_rd_we}, 32'h0);

    // Byte/half loads with extension
    mem[32'h100] = 32'h80123456;
    do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, rd, er, lat);
    chk("lb_sign", rd, 32'hFFFFFF80);
    chk("lb_addr", last_rd_addr, 32'h100);
    do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, rd, er, lat);
    chk("lbu_zero", rd, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, rd, er, lat);
    chk("lh_sign", rd, 32'hFFFF8012);
    do_req(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("lh_pos", rd, 32'h00003456);
    do_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, rd, er, lat);
    chk("lb_lane1", rd, 32'h00000034);

    // SB read-modify-write
    mem[32'h200] = 32'h11223344;
    do_req(1'b1, 2'b00, 1'b0, 32'h201, 32'hFFFFFF5A, rd, er, lat);
    chk("sb_wdata", last_wr_data, 32'h11225A44);
    chk("sb_waddr", last_wr_addr, 32'h200);
    chk("sb_cs_cnt", cs_cnt, 2);
    chk("sb_oe_on_read", oe_bad, 0);
    chk("sb_oe_seen", {31'b0, oe_cnt > 0}, 32'h1);
    chk("sb_lat", lat, 2 * N + 5);
    chk("sb_rdata", rd, 32'h0);
    chk("sb_err", {31'b0, er}, 32'h0);

    // SH into upper half of the updated word
    do_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, rd, er, lat);
    chk("sh_wdata", mem[32'h200], 32'hBEEF5A44);

    // SW
    do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, rd, er, lat);
    chk("sw_mem", mem[32'h400], 32'hCAFEF00D);
    chk("sw_lat", lat, N + 3);
    chk("sw_cs_cnt", cs_cnt, 1);

    // Errors
    do_req(1'b1, 2'b10, 1'b0, 32'h302, 32'h12345678, rd, er, lat);
    chk("sw_mis_err", {31'b0, er}, 32'h1);
    chk("sw_mis_lat", lat, 2);
    chk("sw_mis_cs", cs_cnt, 0);
    do_req(1'b0, 2'b01, 1'b0, 32'h105, 32'h0, rd, er, lat);
    chk("lh_mis_err", {31'b0, er}, 32'h1);
    chk("lh_mis_rdata", rd, 32'h0);
    chk("lh_mis_cs", cs_cnt, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("size11_err", {31'b0, er}, 32'h1);
    do_req(1'b0, 2'b00, 1'b0, 32'h107, 32'h0, rd, er, lat);
    chk("lb_odd_ok", {31'b0, er}, 32'h0);

    // Reset during RD_WAIT, then a stray mem_ready
    mem_en = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h100; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rr_cs", {31'b0, mem_cs}, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rr_ready", {31'b0, req_ready}, 32'h1);
    chk("rr_outputs", {27'b0, rsp_valid, rsp_err, mem_cs, mem_we, mem_oe}, 32'h0);
    chk("rr_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid || mem_cs) seen++;
    end
    chk("rr_no_rsp", seen, 0);
    mem_en = 1'b1;
    mem[32'h100] = 32'h0BADF00D;
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("rr_next_data", rd, 32'h0BADF00D);
    chk("rr_next_lat", lat, N + 3);

`ifdef BRIDGE_TIMEOUT_EN
    mem_en = 1'b0;
    do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd, er, lat);
    chk("to_err", {31'b0, er}, 32'h1);
    chk("to_rdata", rd, 32'h0);
    chk("to_lat", lat, TO + 3);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("to_late_ready", seen, 0);
    mem_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
